// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Each granted access occupies one ACCESS cycle. Read data is captured when the FSM leaves ACCESS.
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wr_en,
    output logic [DW-1:0] ram_wr_data,
    input  logic [DW-1:0] ram_rd_data,
    output logic          busy
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_grant;
    logic          w_win;
    logic          r_last;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_wr_en;
    logic [DW-1:0] r_ram_wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Requests are only looked at in IDLE; a tie goes to whoever did not win last.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_win        = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_grant      = 1'b1;
                    w_state_next = ACCESS;
                    w_win        = (req0 && req1) ? ~r_last : req1;
                end
            end
            ACCESS:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // During ACCESS, r_last identifies the requester that owns the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last        <= 1'b1;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_ram_addr    <= '0;
            r_ram_wr_en   <= 1'b0;
            r_ram_wr_data <= '0;
        end else begin
            r_gnt0    <= w_grant & ~w_win;
            r_gnt1    <= w_grant & w_win;
            r_rvalid0 <= (r_state == ACCESS) && !r_ram_wr_en && !r_last;
            r_rvalid1 <= (r_state == ACCESS) && !r_ram_wr_en && r_last;
            if (w_grant) begin
                r_last        <= w_win;
                r_ram_addr    <= w_win ? addr1  : addr0;
                r_ram_wr_en   <= w_win ? we1    : we0;
                r_ram_wr_data <= w_win ? wdata1 : wdata0;
            end else begin
                r_ram_addr    <= '0;
                r_ram_wr_en   <= 1'b0;
                r_ram_wr_data <= '0;
            end
            if (r_state == ACCESS && !r_ram_wr_en) begin
                if (r_last) r_rdata1 <= ram_rd_data;
                else        r_rdata0 <= ram_rd_data;
            end
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign ram_addr    = r_ram_addr;
    assign ram_wr_en   = r_ram_wr_en;
    assign ram_wr_data = r_ram_wr_data;
    assign busy        = (r_state == ACCESS);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed table-driven bench for ram_arbiter with a behavioural 4-entry RAM.
// Hand-written sequences cover reset while an access is in flight.
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_clr = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [1:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_wr_en, busy;
    logic [7:0] rdata0, rdata1, ram_wr_data, ram_rd_data;
    logic [1:0] ram_addr;
    logic [7:0] mem [4];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(2), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data), .busy(busy)
    );

    // RAM model: combinational read, write committed at the clock edge.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'h50 + 8'(i);
        end else if (ram_wr_en) begin
            mem[ram_addr] <= ram_wr_data;
        end
    end
    assign ram_rd_data = mem[ram_addr];

    typedef struct {
        logic       r0, w0;
        logic [1:0] a0;
        logic [7:0] d0;
        logic       r1, w1;
        logic [1:0] a1;
        logic [7:0] d1;
        logic       g0, g1, v0, v1;
        logic [7:0] rd0, rd1;
        logic [1:0] ra;
        logic       we;
        logic [7:0] wd;
        logic       bsy;
        logic [1:0] ma;
        logic [7:0] mv;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [1:0] a0, input logic [7:0] d0,
        input logic r1, input logic w1, input logic [1:0] a1, input logic [7:0] d1,
        input logic g0, input logic g1, input logic v0, input logic v1,
        input logic [7:0] rd0, input logic [7:0] rd1,
        input logic [1:0] ra, input logic we, input logic [7:0] wd, input logic bsy,
        input logic [1:0] ma, input logic [7:0] mv);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.rd0 = rd0; v.rd1 = rd1; v.ra = ra; v.we = we; v.wd = wd; v.bsy = bsy;
        v.ma = ma; v.mv = mv;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance one clock and check the per-cycle invariants away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        chk("rvalid_onehot", 32'(rvalid0 & rvalid1), 32'd0);
        chk("wr_en_implies_busy", 32'(ram_wr_en & ~busy), 32'd0);
    endtask

    task automatic drive(input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        chk({t, ".gnt0"}, 32'(gnt0), 32'(v.g0));
        chk({t, ".gnt1"}, 32'(gnt1), 32'(v.g1));
        chk({t, ".rvalid0"}, 32'(rvalid0), 32'(v.v0));
        chk({t, ".rvalid1"}, 32'(rvalid1), 32'(v.v1));
        chk({t, ".rdata0"}, 32'(rdata0), 32'(v.rd0));
        chk({t, ".rdata1"}, 32'(rdata1), 32'(v.rd1));
        chk({t, ".ram_addr"}, 32'(ram_addr), 32'(v.ra));
        chk({t, ".ram_wr_en"}, 32'(ram_wr_en), 32'(v.we));
        chk({t, ".ram_wr_data"}, 32'(ram_wr_data), 32'(v.wd));
        chk({t, ".busy"}, 32'(busy), 32'(v.bsy));
        chk({t, ".mem"}, 32'(mem[v.ma]), 32'(v.mv));
        $display("vec %0d: req=%b%b gnt=%b%b rvalid=%b%b rdata=%h/%h ram_addr=%0d we=%b wd=%h busy=%b",
                 i, v.r0, v.r1, gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                 ram_addr, ram_wr_en, ram_wr_data, busy);
    endtask

    initial begin
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic       w;

        // Write A5 to addr 2 by requester 0, then read it back by requester 1.
        tv.push_back(mk(1,1,2'd2,8'hA5, 0,0,2'd0,8'h00, 1,0,0,0, 8'h00,8'h00, 2'd2,1,8'hA5,1, 2'd2,8'h52));
        tv.push_back(mk(1,1,2'd2,8'hA5, 0,0,2'd0,8'h00, 0,0,0,0, 8'h00,8'h00, 2'd0,0,8'h00,0, 2'd2,8'hA5));
        tv.push_back(mk(0,0,2'd0,8'h00, 1,0,2'd2,8'h00, 0,1,0,0, 8'h00,8'h00, 2'd2,0,8'h00,1, 2'd2,8'hA5));
        tv.push_back(mk(0,0,2'd0,8'h00, 1,0,2'd2,8'h00, 0,0,0,1, 8'h00,8'hA5, 2'd0,0,8'h00,0, 2'd2,8'hA5));
        tv.push_back(mk(0,0,2'd0,8'h00, 0,0,2'd0,8'h00, 0,0,0,0, 8'h00,8'hA5, 2'd0,0,8'h00,0, 2'd2,8'hA5));
        // Simultaneous writes: requester 0 wins the tie since 1 won last.
        tv.push_back(mk(1,1,2'd0,8'h11, 1,1,2'd1,8'h22, 1,0,0,0, 8'h00,8'hA5, 2'd0,1,8'h11,1, 2'd0,8'h50));
        tv.push_back(mk(1,1,2'd0,8'h11, 1,1,2'd1,8'h22, 0,0,0,0, 8'h00,8'hA5, 2'd0,0,8'h00,0, 2'd0,8'h11));
        tv.push_back(mk(0,0,2'd0,8'h00, 1,1,2'd1,8'h22, 0,1,0,0, 8'h00,8'hA5, 2'd1,1,8'h22,1, 2'd1,8'h51));
        tv.push_back(mk(0,0,2'd0,8'h00, 1,1,2'd1,8'h22, 0,0,0,0, 8'h00,8'hA5, 2'd0,0,8'h00,0, 2'd1,8'h22));
        // Both requesters reading continuously: grants alternate 0,1,0,1...
        rd0 = 8'h00;
        rd1 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            w = (k % 2) == 1;
            tv.push_back(mk(1,0,2'd0,8'h00, 1,0,2'd1,8'h00, !w,w,0,0, rd0,rd1, w ? 2'd1 : 2'd0,0,8'h00,1, 2'd0,8'h11));
            if (w) rd1 = 8'h22;
            else   rd0 = 8'h11;
            tv.push_back(mk(1,0,2'd0,8'h00, 1,0,2'd1,8'h00, 0,0,!w,w, rd0,rd1, 2'd0,0,8'h00,0, 2'd1,8'h22));
        end

        #2 rst = 1'b1;
        mem_clr = 1'b1;
        #1;
        chk("reset.gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.ram_wr_en", 32'(ram_wr_en), 32'd0);
        step();
        step();
        rst = 1'b0;
        mem_clr = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            step();
            check_vec(i, tv[i]);
        end

        // Reset in the middle of the write cycle must abort the write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'hFF;
        req1 = 1'b0; we1 = 1'b0;
        step();
        chk("abort.gnt0", 32'(gnt0), 32'd1);
        chk("abort.ram_wr_en_before", 32'(ram_wr_en), 32'd1);
        chk("abort.ram_addr_before", 32'(ram_addr), 32'd3);
        #3 rst = 1'b1;
        #1;
        chk("abort.ram_wr_en_async", 32'(ram_wr_en), 32'd0);
        chk("abort.busy_async", 32'(busy), 32'd0);
        chk("abort.gnt0_async", 32'(gnt0), 32'd0);
        chk("abort.ram_addr_async", 32'(ram_addr), 32'd0);
        chk("abort.ram_wr_data_async", 32'(ram_wr_data), 32'd0);
        chk("abort.rdata0_async", 32'(rdata0), 32'd0);
        chk("abort.rdata1_async", 32'(rdata1), 32'd0);
        $display("abort: rst mid-access, ram_wr_en=%b busy=%b", ram_wr_en, busy);
        req0 = 1'b0; we0 = 1'b0;
        step();
        chk("abort.mem3_kept", 32'(mem[3]), 32'h53);
        chk("abort.no_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("abort.busy_in_reset", 32'(busy), 32'd0);
        $display("abort: edge under reset, mem[3]=%h rvalid=%b%b", mem[3], rvalid0, rvalid1);

        // First edge with rst low arbitrates; after reset requester 0 wins a tie.
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3; wdata0 = 8'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3; wdata1 = 8'h00;
        step();
        chk("post_reset.gnt0", 32'(gnt0), 32'd1);
        chk("post_reset.gnt1", 32'(gnt1), 32'd0);
        chk("post_reset.ram_addr", 32'(ram_addr), 32'd3);
        $display("post_reset: gnt=%b%b ram_addr=%0d", gnt0, gnt1, ram_addr);
        step();
        chk("post_reset.rvalid0", 32'(rvalid0), 32'd1);
        chk("post_reset.rdata0", 32'(rdata0), 32'h53);
        chk("post_reset.rdata1", 32'(rdata1), 32'h00);
        $display("post_reset: rvalid=%b%b rdata0=%h", rvalid0, rvalid1, rdata0);
        req0 = 1'b0; req1 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
